// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the multi-port register file.
package regfile_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NRD    = 2;
  localparam int RF_NWR    = 2;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} rf_state_e;
endpackage

// File: rtl/regfile_sb.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on commit.
module regfile_sb import regfile_pkg::*; #(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = RF_NRD,
  parameter int NWR    = RF_NWR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  set_v,
  input  logic [ADDR_W-1:0]     set_addr,
  input  logic [NWR-1:0]        wr_v,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NRD-1:0]        rd_v,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD-1:0]        busy
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pending;

  // Set is applied after the clears so an issue wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (wr_v[i]) pending[waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
      if (set_v) pending[set_addr] <= 1'b1;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_busy
    logic [ADDR_W-1:0] a;
    logic              hit;
    assign a = raddr[r*ADDR_W +: ADDR_W];
    always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NWR; i++)
        if (wr_v[i] && waddr[i*ADDR_W +: ADDR_W] == a) hit = 1'b1;
    end
    assign busy[r] = rd_v[r] & pending[a] & ~hit;
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass, hazard scoreboard
// and a sequential clear engine that zeroes the array after reset or on request.
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = RF_NRD,
  parameter int NWR      = RF_NWR,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        busy,
  input  logic                  iss_v,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  clr_req,
  output logic                  ready
);
  localparam int DEPTH = 2**ADDR_W;

  rf_state_e         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              run, accept, set_v;
  logic [NWR-1:0]    wen;

  assign run    = (state == RUN);
  assign ready  = run;
  // A clear request drops every write and issue of its own cycle.
  assign accept = run & rst & ~clr_req;
  assign set_v  = accept & iss_v & ~(ZERO_REG && iss_addr == '0);

  always_comb begin
    wen = '0;
    for (int i = 0; i < NWR; i++)
      wen[i] = accept & we[i] & ~(ZERO_REG && waddr[i*ADDR_W +: ADDR_W] == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {ADDR_W{1'b1}}) state <= RUN;
        end
        RUN: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Ascending port order lets the highest-index writer land last.
  always_ff @(posedge clk) begin
    if (!run) begin
      regs[clr_cnt] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (wen[i]) regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    assign a = raddr[r*ADDR_W +: ADDR_W];
    always_comb begin
      d = regs[a];
      for (int i = 0; i < NWR; i++)
        if (wen[i] && waddr[i*ADDR_W +: ADDR_W] == a) d = wdata[i*DATA_W +: DATA_W];
      if (!run || !re[r] || (ZERO_REG && a == '0)) d = '0;
    end
    assign rdata[r*DATA_W +: DATA_W] = d;
  end

  regfile_sb #(.ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .flush    (run & clr_req),
    .set_v    (set_v),
    .set_addr (iss_addr),
    .wr_v     (wen),
    .waddr    (waddr),
    .rd_v     (re & {NRD{run}}),
    .raddr    (raddr),
    .busy     (busy)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, multi-cycle clear/reset sequences,
// and random traffic against a behavioural model.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  busy;
  logic        iss_v;
  logic [4:0]  iss_addr;
  logic        clr_req;
  logic        ready;

  int checks = 0;
  int failures = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr(raddr), .rdata(rdata), .busy(busy), .iss_v(iss_v),
    .iss_addr(iss_addr), .clr_req(clr_req), .ready(ready)
  );

  always #5 clk = ~clk;

  // Model: array contents, pending flags, and cycles of clearing still to go.
  logic [31:0] mregs [32];
  bit          mpend [32];
  int          clr_left = 32;

  function automatic logic [4:0] wa(input int i);
    return waddr[i*5 +: 5];
  endfunction
  function automatic logic [4:0] ra(input int i);
    return raddr[i*5 +: 5];
  endfunction
  function automatic logic [31:0] wd(input int i);
    return wdata[i*32 +: 32];
  endfunction

  function automatic bit whit(input int i, input logic [4:0] a);
    return rst && clr_left == 0 && !clr_req && we[i] && wa(i) == a && a != 5'd0;
  endfunction

  function automatic logic [31:0] m_rd(input int p);
    logic [31:0] d;
    logic [4:0]  a;
    a = ra(p);
    if (clr_left != 0 || !re[p] || a == 5'd0) return 32'h0;
    d = mregs[a];
    for (int i = 0; i < 2; i++) if (whit(i, a)) d = wd(i);
    return d;
  endfunction

  function automatic logic m_busy(input int p);
    logic [4:0] a;
    a = ra(p);
    if (clr_left != 0 || !re[p]) return 1'b0;
    return mpend[a] && !whit(0, a) && !whit(1, a);
  endfunction

  task automatic model_edge();
    if (!rst || (clr_left == 0 && clr_req)) begin
      clr_left = 32;
      for (int k = 0; k < 32; k++) begin mregs[k] = 32'h0; mpend[k] = 1'b0; end
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      for (int i = 0; i < 2; i++)
        if (we[i] && wa(i) != 5'd0) begin mregs[wa(i)] = wd(i); mpend[wa(i)] = 1'b0; end
      if (iss_v && iss_addr != 5'd0) mpend[iss_addr] = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_ready", {31'b0, ready}, {31'b0, clr_left == 0});
    chk("model_rdata0", rdata[31:0], m_rd(0));
    chk("model_rdata1", rdata[63:32], m_rd(1));
    chk("model_busy", {30'b0, busy}, {30'b0, m_busy(1), m_busy(0)});
  endtask

  task automatic step(input bit do_chk = 1'b1);
    #1;
    if (do_chk) check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 2'b00; waddr = '0; wdata = '0; re = 2'b00; raddr = '0;
    iss_v = 1'b0; iss_addr = '0; clr_req = 1'b0;
  endtask

  task automatic count_ready(input string nm);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin step(); n++; clr_req = 1'b0; end
    chk(nm, n, 32);
  endtask

  typedef struct packed {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        iss;
    logic [4:0]  ia;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  localparam logic [4:0]  A0 = 5'd0;
  localparam logic [31:0] D0 = 32'h0;
  vec_t tbl [16];

  initial begin
    tbl[0]  = '{2'b01, 5'd5, A0, 32'h12345678, D0, 2'b10, A0, 5'd5, 1'b0, A0, D0, 32'h12345678, 2'b00};
    tbl[1]  = '{2'b00, A0, A0, D0, D0, 2'b10, A0, 5'd5, 1'b0, A0, D0, 32'h12345678, 2'b00};
    tbl[2]  = '{2'b11, 5'd7, 5'd7, 32'hAAAAAAAA, 32'h55555555, 2'b11, 5'd7, 5'd7, 1'b0, A0,
                32'h55555555, 32'h55555555, 2'b00};
    tbl[3]  = '{2'b00, A0, A0, D0, D0, 2'b11, 5'd7, 5'd7, 1'b0, A0, 32'h55555555, 32'h55555555, 2'b00};
    tbl[4]  = '{2'b01, A0, A0, 32'hFFFFFFFF, D0, 2'b01, A0, A0, 1'b0, A0, D0, D0, 2'b00};
    tbl[5]  = '{2'b00, A0, A0, D0, D0, 2'b01, A0, A0, 1'b0, A0, D0, D0, 2'b00};
    tbl[6]  = '{2'b00, A0, A0, D0, D0, 2'b01, 5'd9, A0, 1'b1, 5'd9, D0, D0, 2'b00};
    tbl[7]  = '{2'b00, A0, A0, D0, D0, 2'b01, 5'd9, A0, 1'b0, A0, D0, D0, 2'b01};
    tbl[8]  = '{2'b01, 5'd9, A0, 32'h99, D0, 2'b01, 5'd9, A0, 1'b0, A0, 32'h99, D0, 2'b00};
    tbl[9]  = '{2'b00, A0, A0, D0, D0, 2'b01, 5'd9, A0, 1'b0, A0, 32'h99, D0, 2'b00};
    tbl[10] = '{2'b10, A0, 5'd9, D0, 32'h77, 2'b01, 5'd9, A0, 1'b1, 5'd9, 32'h77, D0, 2'b00};
    tbl[11] = '{2'b00, A0, A0, D0, D0, 2'b01, 5'd9, A0, 1'b0, A0, 32'h77, D0, 2'b01};
    tbl[12] = '{2'b00, A0, A0, D0, D0, 2'b00, 5'd9, 5'd9, 1'b0, A0, D0, D0, 2'b00};
    tbl[13] = '{2'b00, A0, A0, D0, D0, 2'b01, A0, A0, 1'b1, A0, D0, D0, 2'b00};
    tbl[14] = '{2'b00, A0, A0, D0, D0, 2'b11, A0, 5'd9, 1'b0, A0, D0, 32'h77, 2'b10};
    tbl[15] = '{2'b01, 5'd9, A0, 32'h1, D0, 2'b00, A0, A0, 1'b0, A0, D0, D0, 2'b00};

    idle();
    rst = 1'b0;
    for (int k = 0; k < 32; k++) begin mregs[k] = 32'h0; mpend[k] = 1'b0; end
    @(negedge clk);
    re = 2'b11; raddr = {5'd3, 5'd4};
    step(1'b0); step(1'b0); step(1'b0);
    #1;
    chk("reset_ready", {31'b0, ready}, 32'h0);
    chk("reset_rdata", rdata[31:0] | rdata[63:32], 32'h0);
    chk("reset_busy", {30'b0, busy}, 32'h0);

    rst = 1'b1;
    count_ready("reset_to_ready");

    for (int r = 0; r < 32; r += 2) begin
      re = 2'b11; raddr = {5'(r + 1), 5'(r)};
      #1;
      chk("init_zero", rdata[31:0] | rdata[63:32], 32'h0);
      chk("init_busy", {30'b0, busy}, 32'h0);
      step();
    end

    for (int v = 0; v < 16; v++) begin
      we = tbl[v].we; waddr = {tbl[v].wa1, tbl[v].wa0}; wdata = {tbl[v].wd1, tbl[v].wd0};
      re = tbl[v].re; raddr = {tbl[v].ra1, tbl[v].ra0};
      iss_v = tbl[v].iss; iss_addr = tbl[v].ia;
      #1;
      chk($sformatf("vec%0d_rdata0", v), rdata[31:0], tbl[v].e0);
      chk($sformatf("vec%0d_rdata1", v), rdata[63:32], tbl[v].e1);
      chk($sformatf("vec%0d_busy", v), {30'b0, busy}, {30'b0, tbl[v].eb});
      step();
    end
    idle();

    // Fill r1..r31, leave r3 pending, then request a clear.
    for (int r = 1; r < 32; r++) begin
      we = 2'b01; waddr = {5'd0, 5'(r)}; wdata = {32'h0, 32'hC0DE0000 + 32'(r)};
      step();
    end
    idle();
    iss_v = 1'b1; iss_addr = 5'd3; step();
    idle();
    re = 2'b01; raddr = {5'd0, 5'd3};
    #1;
    chk("pre_clr_busy", {30'b0, busy}, 32'h1);
    clr_req = 1'b1; re = 2'b11; raddr = {5'd31, 5'd3};
    step();
    clr_req = 1'b0;
    count_ready("clr_to_ready");
    for (int r = 0; r < 32; r += 2) begin
      re = 2'b11; raddr = {5'(r + 1), 5'(r)};
      #1;
      chk("post_clr_zero", rdata[31:0] | rdata[63:32], 32'h0);
      chk("post_clr_busy", {30'b0, busy}, 32'h0);
      step();
    end

    // Reset at clear cycle 10, then a clr_req mid-clear that must not extend it.
    idle();
    clr_req = 1'b1; step(); clr_req = 1'b0;
    repeat (9) step();
    rst = 1'b0; step(); step();
    rst = 1'b1;
    begin
      int n = 0;
      while (ready !== 1'b1 && n < 100) begin
        clr_req = (n == 5);
        step(); n++;
      end
      clr_req = 1'b0;
      chk("rst_midclear_ready", n, 32);
    end

    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 299) != 0);
      clr_req = ($urandom_range(0, 59) == 0);
      we = 2'($urandom);
      waddr = ($urandom_range(0, 1) != 0) ? 10'($urandom) : {2'b0, 3'($urandom), 2'b0, 3'($urandom)};
      wdata = {$urandom, $urandom};
      re = 2'($urandom);
      raddr = ($urandom_range(0, 1) != 0) ? 10'($urandom) : {2'b0, 3'($urandom), 2'b0, 3'($urandom)};
      iss_v = ($urandom_range(0, 2) == 0);
      iss_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom) : {2'b0, 3'($urandom)};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
